seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder_if.sv | 29 ++
 rtl/seg_scan_decoder.sv | 173 +++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_decoder_if.sv
//============================================================================
// Module : seg_scan_decoder_if
// Desc   : Scanned 7-segment display pins and decoded frame results.
// Rev    : 1.0
//============================================================================
`default_nettype none

interface seg_scan_decoder_if;
  logic [3:0]  anode;
  logic [6:0]  segment;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic        frame_ok;
  logic        seg_err;
  logic        seq_err;
  logic        anode_err;

  modport master (
    output anode, segment,
    input  frame_data, frame_valid, frame_ok, seg_err, seq_err, anode_err
  );

  modport slave (
    input  anode, segment,
    output frame_data, frame_valid, frame_ok, seg_err, seq_err, anode_err
  );
endinterface

`default_nettype wire

// File: rtl/seg_scan_decoder.sv
//============================================================================
// Module : seg_scan_decoder
// Desc   : Recovers 4-digit frames from a multiplexed 7-segment display scan.
// Rev    : 1.0
//============================================================================
`default_nettype none

module seg_scan_decoder #(
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rstN,
  seg_scan_decoder_if.slave  bus
);

  localparam logic [7:0] C_SETTLE = 8'(SETTLE);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] EXP3 = 3'd1;
  localparam logic [2:0] EXP2 = 3'd2;
  localparam logic [2:0] EXP1 = 3'd3;
  localparam logic [2:0] EXP0 = 3'd4;

  logic [3:0]  r_anode;
  logic [3:0]  r_anode_prev;
  logic [6:0]  r_segment;
  logic [7:0]  r_dwell;
  logic [2:0]  r_state;
  logic [3:0]  r_d3, r_d2, r_d1;
  logic        r_bad;
  logic [15:0] r_frame_data;
  logic        r_frame_valid, r_frame_ok;
  logic        r_seg_err, r_seq_err, r_anode_err;

  logic        w_changed, w_strobe;
  logic [7:0]  w_dwell_next;
  logic        w_blank, w_illegal, w_digit;
  logic [1:0]  w_idx, w_exp_idx;
  logic [3:0]  w_val;
  logic        w_seg_bad;

  // Strobe fires only on the cycle the dwell first reaches SETTLE.
  always_comb begin
    w_changed = (r_anode != r_anode_prev);
    if (w_changed)
      w_dwell_next = 8'd1;
    else if (r_dwell >= C_SETTLE)
      w_dwell_next = C_SETTLE;
    else
      w_dwell_next = r_dwell + 8'd1;
    w_strobe = (w_dwell_next == C_SETTLE) && (w_changed || (r_dwell != C_SETTLE));
  end

  always_comb begin
    w_blank   = 1'b0;
    w_illegal = 1'b0;
    w_idx     = 2'd0;
    case (r_anode)
      4'b0111: w_idx = 2'd3;
      4'b1011: w_idx = 2'd2;
      4'b1101: w_idx = 2'd1;
      4'b1110: w_idx = 2'd0;
      4'b1111: w_blank = 1'b1;
      default: w_illegal = 1'b1;
    endcase
    w_digit = !w_blank && !w_illegal;
  end

  always_comb begin
    w_seg_bad = 1'b0;
    case (r_segment)
      7'b1000000: w_val = 4'd0;
      7'b1111001: w_val = 4'd1;
      7'b0100100: w_val = 4'd2;
      7'b0110000: w_val = 4'd3;
      7'b0011001: w_val = 4'd4;
      7'b0010010: w_val = 4'd5;
      7'b0000010: w_val = 4'd6;
      7'b1111000: w_val = 4'd7;
      7'b0000000: w_val = 4'd8;
      7'b0010000: w_val = 4'd9;
      default: begin
        w_val     = 4'hF;
        w_seg_bad = 1'b1;
      end
    endcase
  end

  always_comb begin
    case (r_state)
      EXP3:    w_exp_idx = 2'd3;
      EXP2:    w_exp_idx = 2'd2;
      EXP1:    w_exp_idx = 2'd1;
      default: w_exp_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_anode       <= 4'b1111;
      r_anode_prev  <= 4'b1111;
      r_segment     <= 7'h7F;
      r_dwell       <= 8'd0;
      r_state       <= IDLE;
      r_d3          <= 4'd0;
      r_d2          <= 4'd0;
      r_d1          <= 4'd0;
      r_bad         <= 1'b0;
      r_frame_data  <= 16'h0000;
      r_frame_valid <= 1'b0;
      r_frame_ok    <= 1'b0;
      r_seg_err     <= 1'b0;
      r_seq_err     <= 1'b0;
      r_anode_err   <= 1'b0;
    end else begin
      r_anode       <= bus.anode;
      r_anode_prev  <= r_anode;
      r_segment     <= bus.segment;
      r_dwell       <= w_dwell_next;
      r_frame_valid <= 1'b0;
      r_seg_err     <= 1'b0;
      r_seq_err     <= 1'b0;
      r_anode_err   <= 1'b0;

      if (w_strobe && w_illegal) begin
        r_anode_err <= 1'b1;
        r_state     <= IDLE;
      end else if (w_strobe && w_digit) begin
        r_seg_err <= w_seg_bad;
        // DIGIT3 always opens a new frame; it is out of order unless expected or idle.
        if (w_idx == 2'd3) begin
          r_seq_err <= (r_state != IDLE) && (r_state != EXP3);
          r_d3      <= w_val;
          r_bad     <= w_seg_bad;
          r_state   <= EXP2;
        end else if (r_state == IDLE) begin
          r_state <= IDLE;
        end else if (w_idx == w_exp_idx) begin
          r_bad <= r_bad | w_seg_bad;
          case (w_idx)
            2'd2: begin
              r_d2    <= w_val;
              r_state <= EXP1;
            end
            2'd1: begin
              r_d1    <= w_val;
              r_state <= EXP0;
            end
            default: begin
              r_frame_data  <= {r_d3, r_d2, r_d1, w_val};
              r_frame_ok    <= !(r_bad | w_seg_bad);
              r_frame_valid <= 1'b1;
              r_state       <= EXP3;
            end
          endcase
        end else begin
          r_seq_err <= 1'b1;
          r_state   <= IDLE;
        end
      end
    end
  end

  assign bus.frame_data  = r_frame_data;
  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_ok    = r_frame_ok;
  assign bus.seg_err     = r_seg_err;
  assign bus.seq_err     = r_seq_err;
  assign bus.anode_err   = r_anode_err;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
//============================================================================
// Module : tb_seg_scan_decoder
// Desc   : Drives one scan into SETTLE=1 and SETTLE=3 decoders against a frame model.
// Rev    : 1.0
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_seg_scan_decoder;

  logic       clk = 1'b0;
  logic       rstN;
  logic [3:0] an;
  logic [6:0] sg;

  always #5 clk = ~clk;

  seg_scan_decoder_if bus1 ();
  seg_scan_decoder_if bus3 ();

  assign bus1.anode   = an;
  assign bus1.segment = sg;
  assign bus3.anode   = an;
  assign bus3.segment = sg;

  seg_scan_decoder #(.SETTLE(1)) dut1 (.clk(clk), .rstN(rstN), .bus(bus1));
  seg_scan_decoder #(.SETTLE(3)) dut3 (.clk(clk), .rstN(rstN), .bus(bus3));

  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int settle_of [2] = '{1, 3};

  int total = 0;
  int bad   = 0;

  // Reference: run length of the pin value, and the next digit index expected (-1 = idle).
  int          run   [2];
  logic [3:0]  last  [2];
  int          expi  [2];
  int          dg    [2][4];
  bit          fbad  [2];
  logic [15:0] m_fd  [2];
  bit          m_fok [2];
  bit          p_val [2], p_seg [2], p_seq [2], p_an [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int decode(input logic [6:0] s);
    for (int k = 0; k < 10; k++)
      if (segtab[k] == s) return k;
    return 15;
  endfunction

  function automatic logic [3:0] anode_for(input int idx);
    logic [3:0] a;
    a = 4'hF;
    a[idx] = 1'b0;
    return a;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      run[m] = 0; last[m] = 4'hF; expi[m] = -1; fbad[m] = 0;
      for (int k = 0; k < 4; k++) dg[m][k] = 0;
      m_fd[m] = 16'h0; m_fok[m] = 0;
      p_val[m] = 0; p_seg[m] = 0; p_seq[m] = 0; p_an[m] = 0;
    end
  endtask

  task automatic model_step(input int m, input logic [3:0] a, input logic [6:0] s);
    int nlow, idx, v;
    bit sb;
    p_val[m] = 0; p_seg[m] = 0; p_seq[m] = 0; p_an[m] = 0;
    if (a == last[m]) run[m]++;
    else begin
      last[m] = a;
      run[m] = 1;
    end
    if (run[m] != settle_of[m]) return;
    nlow = 0; idx = -1;
    for (int k = 0; k < 4; k++)
      if (!a[k]) begin nlow++; idx = k; end
    if (nlow == 0) return;
    if (nlow > 1) begin
      p_an[m] = 1;
      expi[m] = -1;
      return;
    end
    v = decode(s);
    sb = (v == 15);
    p_seg[m] = sb;
    if (expi[m] == -1) begin
      if (idx == 3) begin dg[m][3] = v; fbad[m] = sb; expi[m] = 2; end
    end else if (idx == expi[m]) begin
      dg[m][idx] = v;
      fbad[m] = (idx == 3) ? sb : (fbad[m] | sb);
      if (idx == 0) begin
        m_fd[m]  = 16'(dg[m][3] * 4096 + dg[m][2] * 256 + dg[m][1] * 16 + dg[m][0]);
        m_fok[m] = !fbad[m];
        p_val[m] = 1;
        expi[m]  = 3;
      end else expi[m] = idx - 1;
    end else begin
      p_seq[m] = 1;
      if (idx == 3) begin dg[m][3] = v; fbad[m] = sb; expi[m] = 2; end
      else expi[m] = -1;
    end
  endtask

  task automatic cmp1(input string p, input int m, input logic [15:0] fd, input logic fv,
                      input logic fok, input logic se, input logic sq, input logic ae);
    check({p, ".frame_data"},  32'(fd),  32'(m_fd[m]));
    check({p, ".frame_valid"}, 32'(fv),  32'(p_val[m]));
    check({p, ".frame_ok"},    32'(fok), 32'(m_fok[m]));
    check({p, ".seg_err"},     32'(se),  32'(p_seg[m]));
    check({p, ".seq_err"},     32'(sq),  32'(p_seq[m]));
    check({p, ".anode_err"},   32'(ae),  32'(p_an[m]));
  endtask

  task automatic compare_all();
    cmp1("s1", 0, bus1.frame_data, bus1.frame_valid, bus1.frame_ok, bus1.seg_err, bus1.seq_err, bus1.anode_err);
    cmp1("s3", 1, bus3.frame_data, bus3.frame_valid, bus3.frame_ok, bus3.seg_err, bus3.seq_err, bus3.anode_err);
  endtask

  task automatic cyc(input logic [3:0] a, input logic [6:0] s);
    an = a;
    sg = s;
    @(posedge clk);
    #1;
    compare_all();
    if (rstN) begin
      model_step(0, a, s);
      model_step(1, a, s);
    end
  endtask

  task automatic dig(input int idx, input int val, input int hold);
    repeat (hold) cyc(anode_for(idx), segtab[val]);
  endtask

  task automatic blank(input int n);
    repeat (n) cyc(4'hF, 7'h7F);
  endtask

  task automatic scan4(input int a3, input int a2, input int a1, input int a0, input int hold, input int gap);
    dig(3, a3, hold); blank(gap);
    dig(2, a2, hold); blank(gap);
    dig(1, a1, hold); blank(gap);
    dig(0, a0, hold); blank(gap);
  endtask

  // Asynchronous reset taken mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic hit_reset();
    rstN = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rstN = 1'b1;
  endtask

  initial begin
    logic [3:0] a;
    logic [6:0] s;
    int nxt, r, hold;

    rstN = 1'b0;
    an = 4'hF;
    sg = 7'h7F;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rstN = 1'b1;

    // Continuous one-clock-per-digit scan of 9,1,1,3.
    repeat (4) scan4(9, 1, 1, 3, 1, 0);
    blank(2);
    check("scan.fd", 32'(bus1.frame_data), 32'h9113);
    check("scan.ok", 32'(bus1.frame_ok), 32'h1);

    // Scan entering at DIGIT1 after reset.
    hit_reset();
    dig(1, 4, 1);
    dig(0, 7, 1);
    scan4(1, 2, 3, 4, 1, 0);
    blank(2);
    check("late.fd", 32'(bus1.frame_data), 32'h1234);

    // Blank segment pattern on DIGIT2, then a clean frame.
    dig(3, 9, 1);
    cyc(anode_for(2), 7'b1111111);
    dig(1, 1, 1);
    dig(0, 3, 1);
    blank(2);
    check("segbad.fd", 32'(bus1.frame_data), 32'h9F13);
    check("segbad.ok", 32'(bus1.frame_ok), 32'h0);
    scan4(9, 1, 1, 3, 1, 0);
    blank(2);
    check("segclean.ok", 32'(bus1.frame_ok), 32'h1);

    // Skipped DIGIT2.
    dig(3, 8, 1);
    dig(1, 8, 1);
    dig(0, 8, 1);
    blank(2);
    check("skip.fd", 32'(bus1.frame_data), 32'h9113);
    scan4(5, 6, 7, 8, 1, 0);
    blank(2);
    check("skip.next", 32'(bus1.frame_data), 32'h5678);

    // Slow scan with blanking for SETTLE=3, then an illegal anode mid-frame.
    scan4(2, 0, 2, 5, 4, 2);
    check("slow.fd", 32'(bus3.frame_data), 32'h2025);
    dig(3, 1, 4); blank(2);
    dig(2, 1, 4); blank(2);
    repeat (4) cyc(4'b0000, segtab[8]);
    dig(1, 1, 4); blank(2);
    dig(0, 1, 4); blank(2);
    check("illegal.fd", 32'(bus3.frame_data), 32'h2025);

    // Reset while waiting for DIGIT1.
    dig(3, 6, 1);
    dig(2, 6, 1);
    hit_reset();
    dig(1, 6, 1);
    dig(0, 6, 1);
    blank(1);
    check("rst.fd", 32'(bus1.frame_data), 32'h0000);
    scan4(4, 3, 2, 1, 1, 0);
    blank(2);
    check("rst.next", 32'(bus1.frame_data), 32'h4321);

    // Randomised scanning with glitches, blanking, illegal anodes and resets.
    nxt = 3;
    repeat (600) begin
      r = $urandom_range(0, 99);
      s = ($urandom_range(0, 9) == 0) ? 7'($urandom) : segtab[$urandom_range(0, 9)];
      hold = $urandom_range(1, 4);
      a = 4'hF;
      if (r < 70) begin
        a = anode_for(nxt);
        nxt = (nxt == 0) ? 3 : nxt - 1;
      end else if (r < 82) begin
        a = anode_for($urandom_range(0, 3));
      end else if (r < 92) begin
        a = 4'hF;
      end else if (r < 98) begin
        do a = 4'($urandom); while ($countones(a) > 2);
      end else begin
        hit_reset();
        continue;
      end
      repeat (hold) cyc(a, s);
    end
    blank(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
